alu_mc: RTL and testbench

Parametrised multi-cycle ALU, successor to the 16-bit combinational datapath ALU. It adds a registered result, a valid/ready handshake on both sides, and a Z/N/V status register. It also adds an iterative shift-add multiply that is optional at build time. It sits between the register-file read stage and write-back, and the controller FSM drives it through the handshake.

---
 rtl/alu_mc_pkg.sv | 21 ++
 rtl/alu_mc_mul.sv | 68 ++++++
 rtl/alu_mc.sv | 131 +++++++++++++
 tb/tb_alu_mc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc shared definitions: opcodes, status bit indices, FSM states.
// Imported by alu_mc (top) and alu_mc_mul.
package alu_mc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam int ST_Z = 0;
  localparam int ST_N = 1;
  localparam int ST_V = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier, one bit of B per cycle, LSB first.
// product_o is the accumulator value after the current iteration.
module alu_mc_mul
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               run_q, run_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] sum;

  assign sum       = acc_q + (b_q[0] ? a_q : '0);
  assign done_o    = run_q && (cnt_q == LAST);
  assign product_o = sum;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      a_d   = {{WIDTH{1'b0}}, a_i};
      b_d   = b_i;
      acc_d = '0;
    end else if (run_q) begin
      acc_d = sum;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result, Z/N/V status and handshakes.
// Optional multiplier enabled by defining ALU_MC_MUL_EN.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [2:0]       aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       status,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       st_q, st_d;
  logic             accept;
  logic [WIDTH-1:0] res;
  logic             res_v;

  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign status    = st_q;

  always_comb begin
    res   = '0;
    res_v = 1'b0;
    unique case (1'b1)
      aluop == OP_ADD: begin
        res   = ain + bin;
        res_v = (ain[MSB] == bin[MSB]) &&
                (res[MSB] != ain[MSB]);
      end
      aluop == OP_SUB: begin
        res   = ain - bin;
        res_v = (ain[MSB] != bin[MSB]) &&
                (res[MSB] != ain[MSB]);
      end
      aluop == OP_AND: res = ain & bin;
      aluop == OP_NOT: res = ~bin;
      default: ;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = accept && (aluop == OP_MUL);
  assign busy      = (state_q == MUL_RUN);

  alu_mc_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (mul_start),
    .a_i      (ain),
    .b_i      (bin),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    st_d    = st_q;
    unique case (state_q)
      IDLE: ;
`ifdef ALU_MC_MUL_EN
      MUL_RUN: begin
        if (mul_done) begin
          out_d       = mul_prod[WIDTH-1:0];
          st_d        = '0;
          st_d[ST_Z]  = (mul_prod[WIDTH-1:0] == '0);
          st_d[ST_N]  = mul_prod[MSB];
          st_d[ST_V]  = |mul_prod[2*WIDTH-1:WIDTH];
          state_d     = DONE;
        end
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A new accept overrides the DONE->IDLE drain, so there is no bubble
    if (accept) begin
`ifdef ALU_MC_MUL_EN
      if (aluop == OP_MUL) state_d = MUL_RUN;
      else
`endif
      begin
        out_d      = res;
        st_d       = '0;
        st_d[ST_Z] = (res == '0);
        st_d[ST_N] = res[MSB];
        st_d[ST_V] = res_v;
        state_d    = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      st_q    <= st_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: vector table, hand sequences,
// and random ops against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic [2:0]   aluop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_w;
  logic [2:0]   status;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ain      (ain),
    .bin      (bin),
    .aluop    (aluop),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out_w),
    .status   (status),
    .busy     (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] eo;
    logic [2:0]   es;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                input logic [2:0] op,
                                output logic [W-1:0] r,
                                output logic [2:0] st,
                                output int lat);
    longint sa, sb, full, smax, smin, prod;
    logic v;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (64'sd1 <<< (W - 1)) - 1;
    smin = -(64'sd1 <<< (W - 1));
    v    = 1'b0;
    lat  = 1;
    r    = '0;
    case (op)
      3'd0: begin
        full = sa + sb;
        r    = W'(full);
        v    = (full > smax) || (full < smin);
      end
      3'd1: begin
        full = sa - sb;
        r    = W'(full);
        v    = (full > smax) || (full < smin);
      end
      3'd2: r = a & b;
      3'd3: r = ~b;
`ifdef ALU_MC_MUL_EN
      3'd4: begin
        prod = longint'(a) * longint'(b);
        r    = W'(prod);
        v    = prod >= (64'sd1 <<< W);
        lat  = W + 1;
      end
`endif
      default: r = '0;
    endcase
    st = {v, r[W-1], (r == '0)};
  endfunction

  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] op,
                        input logic [W-1:0] eo, input logic [2:0] es,
                        input int elat);
    int lat;
    @(negedge clk);
    chk({name, ".in_ready"}, in_ready, 1'b1);
    ain       = a;
    bin       = b;
    aluop     = op;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ain      = W'($urandom);
    bin      = W'($urandom);
    aluop    = 3'($urandom);
    lat      = 1;
    while (!out_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ".valid"}, out_valid, 1'b1);
    chk({name, ".lat"}, lat, elat);
    chk({name, ".out"}, out_w, eo);
    chk({name, ".status"}, status, es);
  endtask

  initial begin
    logic [W-1:0] ra, rb, eo;
    logic [2:0]   rop, es;
    int           elat, nb;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ain       = '0;
    bin       = '0;
    aluop     = '0;

    vecs.push_back('{16'd5,    16'd7,    3'd0, 16'd12,   3'b000});
    vecs.push_back('{16'd10,   16'd3,    3'd1, 16'd7,    3'b000});
    vecs.push_back('{16'd45,   16'd45,   3'd1, 16'd0,    3'b001});
    vecs.push_back('{16'h4000, 16'h4000, 3'd0, 16'h8000, 3'b110});
    vecs.push_back('{16'h1234, 16'h00FF, 3'd3, 16'hFF00, 3'b010});
    vecs.push_back('{16'd15,   16'd60,   3'd2, 16'd12,   3'b000});
    vecs.push_back('{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 3'b100});
    vecs.push_back('{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 3'b001});
    vecs.push_back('{16'h8000, 16'h8000, 3'd0, 16'h0000, 3'b101});
    vecs.push_back('{16'h1234, 16'h5678, 3'd5, 16'h0000, 3'b001});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 3'd7, 16'h0000, 3'b001});
`ifndef ALU_MC_MUL_EN
    vecs.push_back('{16'd300,  16'd300,  3'd4, 16'h0000, 3'b001});
`endif

    repeat (2) @(negedge clk);
    chk("rst.out", out_w, '0);
    chk("rst.status", status, 3'b000);
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", in_ready, 1'b1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
             vecs[i].op, vecs[i].eo, vecs[i].es, 1);

    // Stall: ADD held while AND waits, then accepted on the release edge
    @(negedge clk);
    ain = 16'd20; bin = 16'd22; aluop = 3'd0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    ain = 16'd15; bin = 16'd60; aluop = 3'd2;
    for (int i = 0; i < 3; i++) begin
      chk("hold.valid", out_valid, 1'b1);
      chk("hold.out", out_w, 16'd42);
      chk("hold.in_ready", in_ready, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("hold.release_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.valid", out_valid, 1'b1);
    chk("b2b.out", out_w, 16'd12);
    chk("b2b.status", status, 3'b000);
    @(negedge clk);
    chk("b2b.drain", out_valid, 1'b0);

`ifdef ALU_MC_MUL_EN
    // MUL 300x300: busy window then product
    @(negedge clk);
    ain = 16'd300; bin = 16'd300; aluop = 3'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    nb = 0;
    while (busy && nb < 4 * W) begin
      chk("mul.no_valid", out_valid, 1'b0);
      nb++;
      @(negedge clk);
    end
    chk("mul.busy_cycles", nb, W);
    chk("mul.valid", out_valid, 1'b1);
    chk("mul.out", out_w, 16'h5F90);
    chk("mul.status", status, 3'b100);

    // Reset during MUL aborts it
    @(negedge clk);
    ain = 16'd300; bin = 16'd300; aluop = 3'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort.busy_before", busy, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort.valid", out_valid, 1'b0);
    chk("abort.out", out_w, '0);
    chk("abort.busy", busy, 1'b0);
    chk("abort.in_ready", in_ready, 1'b1);
    repeat (W + 2) @(negedge clk);
    chk("abort.no_late_valid", out_valid, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 3'($urandom_range(7, 0));
      if (i % 4 == 0) rb = W'($urandom_range(3, 0));
      model(ra, rb, rop, eo, es, elat);
      run_op($sformatf("rnd%0d", i), ra, rb, rop, eo, es, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
